// File: rtl/door_pkg.sv
// Shared definitions for the door actuator: state encodings shown on state_o
// and a helper for sizing the shared countdown timer.
package door_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_LOCKED   = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_OPEN     = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_ALARM    = 3'd4
  } state_e;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/door_actuator_sync2.sv
// Two-flop synchronizer bringing the asynchronous door sensor into the clk domain.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/door_actuator.sv
// Door latch controller behind the keypad lock: timed unlock, error lockout,
// and (when DOOR_ALARM_EN is defined) forced-open / held-open alarm.
module door_actuator
  import door_pkg::*;
#(
  parameter int UNLOCK_CYCLES  = 16,
  parameter int OPEN_TIMEOUT   = 32,
  parameter int MAX_ERRORS     = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               unlock,
  input  logic               code_err,
  input  logic               door_open,
  output logic               latch_drive,
  output logic               alarm,
  output logic               lockout,
  output logic               ctrl_clr,
  output logic [STATE_W-1:0] state_o
);

  localparam int T_MAX   = max4(UNLOCK_CYCLES, OPEN_TIMEOUT, MAX_ERRORS, LOCKOUT_CYCLES);
  localparam int TIMER_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam int ERR_W   = (MAX_ERRORS > 0) ? $clog2(MAX_ERRORS + 1) : 1;

  localparam logic [TIMER_W-1:0] UNLOCK_LOAD  = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] OPEN_LOAD    = TIMER_W'(OPEN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] LOCKOUT_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
  localparam logic [ERR_W-1:0]   ERR_LIMIT    = ERR_W'(MAX_ERRORS);

  logic               door_s;
  logic               unlock_q, err_q;
  logic               unlock_r, err_r;
  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0]   err_cnt_inc;
  logic               ctrl_clr_q, ctrl_clr_d;

  sync2 u_door_sync (
    .clk (clk),
    .rst (rst),
    .d   (door_open),
    .q   (door_s)
  );

  assign unlock_r    = unlock & ~unlock_q;
  assign err_r       = code_err & ~err_q;
  assign err_cnt_inc = err_cnt_q + ERR_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unlock_q   <= 1'b0;
      err_q      <= 1'b0;
      state_q    <= ST_LOCKED;
      timer_q    <= '0;
      err_cnt_q  <= '0;
      ctrl_clr_q <= 1'b0;
    end else begin
      unlock_q   <= unlock;
      err_q      <= code_err;
      state_q    <= state_d;
      timer_q    <= timer_d;
      err_cnt_q  <= err_cnt_d;
      ctrl_clr_q <= ctrl_clr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_LOCKED: begin
        if (unlock_r) begin
          state_d   = ST_UNLOCKED;
          timer_d   = UNLOCK_LOAD;
          err_cnt_d = '0;
        end else if (err_r) begin
          if (err_cnt_inc == ERR_LIMIT) begin
            state_d   = ST_LOCKOUT;
            timer_d   = LOCKOUT_LOAD;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_inc;
          end
        end
`ifdef DOOR_ALARM_EN
        else if (door_s) begin
          state_d = ST_ALARM;
        end
`endif
      end
      ST_UNLOCKED: begin
        if (door_s) begin
          state_d = ST_OPEN;
          timer_d = OPEN_LOAD;
        end else if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_OPEN: begin
        if (!door_s) begin
          state_d = ST_LOCKED;
        end else if (timer_q == '0) begin
`ifdef DOOR_ALARM_EN
          state_d = ST_ALARM;
`else
          state_d = ST_OPEN;
`endif
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = ST_LOCKED;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
`ifdef DOOR_ALARM_EN
      ST_ALARM: begin
        if (unlock_r) begin
          state_d   = ST_UNLOCKED;
          timer_d   = UNLOCK_LOAD;
          err_cnt_d = '0;
        end
      end
`endif
      default: begin
        state_d = ST_LOCKED;
        timer_d = '0;
      end
    endcase
  end

  // Keypad clear: pulse after any attempt, but held for the whole lockout window.
  always_comb begin
    ctrl_clr_d = (state_d == ST_LOCKOUT) |
                 ((unlock_r | err_r) & (state_q != ST_LOCKOUT));
  end

  always_comb begin
    latch_drive = (state_q == ST_UNLOCKED) | (state_q == ST_OPEN);
    lockout     = (state_q == ST_LOCKOUT);
`ifdef DOOR_ALARM_EN
    alarm       = (state_q == ST_ALARM);
`else
    alarm       = 1'b0;
`endif
    ctrl_clr    = ctrl_clr_q;
    state_o     = state_q;
  end

endmodule

// File: tb/tb_door_actuator.sv
// Directed bench for door_actuator: expected outputs are queued per step and
// checked against the DUT one cycle later.
module tb_door_actuator;

  logic       clk = 1'b0;
  logic       rst;
  logic       unlock;
  logic       code_err;
  logic       door_open;
  logic       latch_drive;
  logic       alarm;
  logic       lockout;
  logic       ctrl_clr;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  door_actuator dut (
    .clk         (clk),
    .rst         (rst),
    .unlock      (unlock),
    .code_err    (code_err),
    .door_open   (door_open),
    .latch_drive (latch_drive),
    .alarm       (alarm),
    .lockout     (lockout),
    .ctrl_clr    (ctrl_clr),
    .state_o     (state_o)
  );

  typedef struct {
    string      tag;
    int         sel;
    logic [2:0] exp;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  function automatic logic [2:0] pick(input int sel);
    case (sel)
      0:       return {2'b00, latch_drive};
      1:       return {2'b00, ctrl_clr};
      2:       return {2'b00, lockout};
      3:       return {2'b00, alarm};
      4:       return state_o;
      default: return 3'bxxx;
    endcase
  endfunction

  task automatic push_all(input string tag, input logic l, input logic c,
                          input logic k, input logic a, input logic [2:0] s);
    sb.push_back('{{tag, ".latch"},   0, {2'b00, l}});
    sb.push_back('{{tag, ".clr"},     1, {2'b00, c}});
    sb.push_back('{{tag, ".lockout"}, 2, {2'b00, k}});
    sb.push_back('{{tag, ".alarm"},   3, {2'b00, a}});
    sb.push_back('{{tag, ".state"},   4, s});
  endtask

  task automatic drain();
    sb_t        e;
    logic [2:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = pick(e.sel);
      total++;
      assert (obs === e.exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
      $display("check %s observed=%0d expected=%0d", e.tag, obs, e.exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expect the given outputs after the next active edge.
  task automatic step(input string tag, input logic l, input logic c,
                      input logic k, input logic a, input logic [2:0] s);
    push_all(tag, l, c, k, a, s);
    cyc();
    drain();
  endtask

  // Expect the given outputs without any clock edge (asynchronous reset).
  task automatic now(input string tag, input logic l, input logic c,
                     input logic k, input logic a, input logic [2:0] s);
    push_all(tag, l, c, k, a, s);
    #1;
    drain();
  endtask

  task automatic err_pulse(input string tag);
    code_err = 1'b1;
    step({tag, "_hit"}, 0, 1, 0, 0, 3'd0);
    code_err = 1'b0;
    step({tag, "_rel"}, 0, 0, 0, 0, 3'd0);
  endtask

  task automatic unlock_window(input string tag);
    unlock = 1'b1;
    step({tag, "_unl"}, 1, 1, 0, 0, 3'd1);
    unlock = 1'b0;
    for (int i = 1; i < 16; i++) step($sformatf("%s_win%0d", tag, i), 1, 0, 0, 0, 3'd1);
    step({tag, "_relock"}, 0, 0, 0, 0, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    unlock    = 1'b0;
    code_err  = 1'b0;
    door_open = 1'b0;
    #2;
    now("reset", 0, 0, 0, 0, 3'd0);
    cyc();
    cyc();
    rst = 1'b0;
    step("idle", 0, 0, 0, 0, 3'd0);

    // Unlock with door closed: latch high exactly 16 cycles, one clear pulse.
    unlock_window("t1");

    // Unlock, door opens and closes again.
    unlock = 1'b1;
    step("t2_unl", 1, 1, 0, 0, 3'd1);
    unlock = 1'b0;
    for (int i = 0; i < 4; i++) step($sformatf("t2_pre%0d", i), 1, 0, 0, 0, 3'd1);
    door_open = 1'b1;
    for (int i = 0; i < 10; i++)
      step($sformatf("t2_open%0d", i), 1, 0, 0, 0, (i < 2) ? 3'd1 : 3'd2);
    door_open = 1'b0;
    step("t2_close0", 1, 0, 0, 0, 3'd2);
    step("t2_close1", 1, 0, 0, 0, 3'd2);
    step("t2_close2", 0, 0, 0, 0, 3'd0);

    // Three rejected codes -> lockout, unlock ignored inside it.
    err_pulse("t3_e0");
    err_pulse("t3_e1");
    code_err = 1'b1;
    step("t3_e2", 0, 1, 1, 0, 3'd3);
    code_err = 1'b0;
    for (int i = 1; i < 64; i++) begin
      if (i == 10) unlock = 1'b1;
      if (i == 11) unlock = 1'b0;
      step($sformatf("t3_lk%0d", i), 0, 1, 1, 0, 3'd3);
    end
    step("t3_exit", 0, 0, 0, 0, 3'd0);

    // Accepted code clears the error count.
    err_pulse("t4_a0");
    err_pulse("t4_a1");
    unlock_window("t4");
    err_pulse("t4_b0");
    err_pulse("t4_b1");
    code_err = 1'b1;
    step("t4_b2", 0, 1, 1, 0, 3'd3);
    code_err = 1'b0;
    step("t4_lk1", 0, 1, 1, 0, 3'd3);
    step("t4_lk2", 0, 1, 1, 0, 3'd3);

    // Asynchronous reset during lockout.
    #2;
    rst = 1'b1;
    now("t5_rst_lk", 0, 0, 0, 0, 3'd0);
    cyc();
    rst = 1'b0;
    step("t5_post_lk", 0, 0, 0, 0, 3'd0);

    // Asynchronous reset during the unlock window.
    unlock = 1'b1;
    step("t5_unl", 1, 1, 0, 0, 3'd1);
    unlock = 1'b0;
    step("t5_win1", 1, 0, 0, 0, 3'd1);
    step("t5_win2", 1, 0, 0, 0, 3'd1);
    #2;
    rst = 1'b1;
    now("t5_rst_unl", 0, 0, 0, 0, 3'd0);
    cyc();
    rst = 1'b0;
    step("t5_post_unl", 0, 0, 0, 0, 3'd0);

`ifdef DOOR_ALARM_EN
    // Forced open while locked raises the alarm after sync + update latency.
    door_open = 1'b1;
    step("t6_f0", 0, 0, 0, 0, 3'd0);
    step("t6_f1", 0, 0, 0, 0, 3'd0);
    step("t6_f2", 0, 0, 0, 1, 3'd4);
    door_open = 1'b0;
    for (int i = 0; i < 5; i++) step($sformatf("t6_hold%0d", i), 0, 0, 0, 1, 3'd4);
    unlock_window("t6");

    // Door held open past the timeout.
    unlock = 1'b1;
    step("t7_unl", 1, 1, 0, 0, 3'd1);
    unlock = 1'b0;
    door_open = 1'b1;
    for (int k = 2; k <= 40; k++) begin
      logic [2:0] st;
      st = (k < 4) ? 3'd1 : ((k < 36) ? 3'd2 : 3'd4);
      step($sformatf("t7_c%0d", k), (st != 3'd4), 0, 0, (st == 3'd4), st);
    end
    door_open = 1'b0;
    #2;
    rst = 1'b1;
    now("t7_rst", 0, 0, 0, 0, 3'd0);
    cyc();
    rst = 1'b0;
    step("t7_post", 0, 0, 0, 0, 3'd0);
`else
    // Door opened while locked: no alarm in this build.
    door_open = 1'b1;
    for (int i = 0; i < 6; i++) step($sformatf("t6_f%0d", i), 0, 0, 0, 0, 3'd0);
    door_open = 1'b0;
    for (int i = 0; i < 3; i++) step($sformatf("t6_c%0d", i), 0, 0, 0, 0, 3'd0);

    // Door held open well past the timeout: OPEN holds.
    unlock = 1'b1;
    step("t7_unl", 1, 1, 0, 0, 3'd1);
    unlock = 1'b0;
    door_open = 1'b1;
    for (int k = 2; k <= 45; k++)
      step($sformatf("t7_c%0d", k), 1, 0, 0, 0, (k < 4) ? 3'd1 : 3'd2);
    door_open = 1'b0;
    step("t7_close0", 1, 0, 0, 0, 3'd2);
    step("t7_close1", 1, 0, 0, 0, 3'd2);
    step("t7_close2", 0, 0, 0, 0, 3'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
